mmio_bus_ctrl: RTL and testbench

Parametrised memory-mapped bus controller between the core's data port and N peripheral slaves (RAM, UART, GPIO, future timers). It generalises fixed-map RAM/UART/GPIO decoding to N configurable base/mask regions. Every slave gets a request/acknowledge handshake with variable wait states. It adds per-access timeout, decode-error response and a sticky error-capture register. It sits between core_risc_v and the peripheral instances in the top level and replaces the separate decoder and read-data mux.

---
 rtl/mmio_bus_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: decodes core accesses onto N base/mask slave
// regions with req/ack handshake, per-access timeout and sticky error capture.
module mmio_bus_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_SLAVES   = 4,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {N_SLAVES{32'hFFFF_0000}},
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_req,
    input  logic                           m_we,
    input  logic [ADDR_WIDTH-1:0]          m_addr,
    input  logic [DATA_WIDTH-1:0]          m_wdata,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic                           m_ready,
    output logic                           m_err,
    output logic [N_SLAVES-1:0]            s_sel,
    output logic                           s_we,
    output logic [ADDR_WIDTH-1:0]          s_addr,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]            s_ack,
    output logic                           err_valid,
    output logic [ADDR_WIDTH-1:0]          err_addr,
    input  logic                           err_clr
);

    // state  | meaning
    // IDLE   | waiting for m_req; address decoded on request
    // ACCESS | one slave selected, waiting for its s_ack or the timeout
    // RESP   | m_ready pulse (m_err on decode miss or timeout)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Timeout is a down-counter holding the ACCESS cycles still allowed.
    localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [N_SLAVES-1:0]     sel_d;
    logic                    we_d;
    logic [ADDR_WIDTH-1:0]   saddr_d;
    logic [DATA_WIDTH-1:0]   swdata_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    ready_d;
    logic                    merr_d;
    logic                    err_valid_d;
    logic [ADDR_WIDTH-1:0]   err_addr_d;
    logic                    new_err;
    logic [ADDR_WIDTH-1:0]   new_err_addr;

    logic [ADDR_WIDTH-1:0]   region_mask [N_SLAVES];
    logic [ADDR_WIDTH-1:0]   region_base [N_SLAVES];
    logic [DATA_WIDTH-1:0]   slave_rdata [N_SLAVES];

    logic                    hit;
    logic [N_SLAVES-1:0]     hit_sel;
    logic [ADDR_WIDTH-1:0]   hit_off;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    ack_sel;

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_slice
        assign region_mask[g] = ADDR_MASKS[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign region_base[g] = BASE_ADDRS[g*ADDR_WIDTH +: ADDR_WIDTH] & region_mask[g];
        assign slave_rdata[g] = s_rdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the top so the lowest matching index is the last to win.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        hit_off = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & region_mask[i]) == region_base[i]) begin
                hit        = 1'b1;
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                hit_off    = m_addr & ~region_mask[i];
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_sel[i]) begin
                sel_rdata = sel_rdata | slave_rdata[i];
            end
        end
    end

    assign ack_sel = |(s_ack & s_sel);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        sel_d        = s_sel;
        we_d         = s_we;
        saddr_d      = s_addr;
        swdata_d     = s_wdata;
        rdata_d      = m_rdata;
        ready_d      = 1'b0;
        merr_d       = 1'b0;
        new_err      = 1'b0;
        new_err_addr = '0;

        case (state_q)
            IDLE: begin
                if (m_req) begin
                    req_addr_d = m_addr;
                    if (hit) begin
                        state_d  = ACCESS;
                        sel_d    = hit_sel;
                        we_d     = m_we;
                        saddr_d  = hit_off;
                        swdata_d = m_wdata;
                        cnt_d    = TO_LOAD;
                    end else begin
                        state_d      = RESP;
                        ready_d      = 1'b1;
                        merr_d       = 1'b1;
                        new_err      = 1'b1;
                        new_err_addr = m_addr;
                        if (!m_we) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            ACCESS: begin
                // An ack in the last allowed cycle still completes normally.
                if (ack_sel) begin
                    if (!s_we) begin
                        rdata_d = sel_rdata;
                    end
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = RESP;
                    ready_d = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    if (!s_we) begin
                        rdata_d = '0;
                    end
                    sel_d        = '0;
                    we_d         = 1'b0;
                    state_d      = RESP;
                    ready_d      = 1'b1;
                    merr_d       = 1'b1;
                    new_err      = 1'b1;
                    new_err_addr = req_addr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear that coincides with a new error keeps the new one.
        err_valid_d = err_valid;
        err_addr_d  = err_addr;
        if (new_err && (err_clr || !err_valid)) begin
            err_valid_d = 1'b1;
            err_addr_d  = new_err_addr;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_addr_q <= '0;
            s_sel      <= '0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            m_rdata    <= '0;
            m_ready    <= 1'b0;
            m_err      <= 1'b0;
            err_valid  <= 1'b0;
            err_addr   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            s_sel      <= sel_d;
            s_we       <= we_d;
            s_addr     <= saddr_d;
            s_wdata    <= swdata_d;
            m_rdata    <= rdata_d;
            m_ready    <= ready_d;
            m_err      <= merr_d;
            err_valid  <= err_valid_d;
            err_addr   <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: transaction-level model of the 3-slave map with
// per-cycle output comparison plus literal checks of the key scenarios.
module tb_mmio_bus_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [2:0]  s_sel;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [95:0] s_rdata;
    logic [2:0]  s_ack;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_clr;

    mmio_bus_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .N_SLAVES  (3),
        .BASE_ADDRS({32'h1003_0000, 32'h1002_0000, 32'h1001_0000}),
        .ADDR_MASKS({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000}),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .s_sel    (s_sel),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .s_ack    (s_ack),
        .err_valid(err_valid),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] map_base [3];
    logic [31:0] map_mask [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    logic [2:0]  exp_sel;
    logic        exp_we;
    logic [31:0] exp_saddr;
    logic [31:0] exp_swdata;
    logic        exp_ready;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        mdl_err_valid;
    logic [31:0] mdl_err_addr;
    logic        pend_err;
    logic [31:0] pend_addr;
    logic        noise;
    logic        hold_req;
    int          last_t0;

    int          obs_ready_cyc = -1;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_sel_cyc = -1;
    logic [2:0]  obs_sel;
    logic [31:0] obs_saddr;
    logic [31:0] obs_swdata;
    logic        obs_swe;
    int          obs_sel_len = 0;
    int          n_ready = 0;
    logic [2:0]  prev_sel = 3'b000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 3; i++) begin
            if ((a & map_mask[i]) == (map_base[i] & map_mask[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [95:0] rand96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock; afterwards the error-capture model absorbs that edge.
    task automatic step();
        logic c;
        logic r;
        c = err_clr;
        r = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            mdl_err_valid = 1'b0;
            mdl_err_addr  = '0;
            exp_sel       = '0;
            exp_we        = 1'b0;
            exp_ready     = 1'b0;
            exp_err       = 1'b0;
            exp_saddr     = '0;
            exp_swdata    = '0;
            exp_rdata     = '0;
        end else if (pend_err && (c || !mdl_err_valid)) begin
            mdl_err_valid = 1'b1;
            mdl_err_addr  = pend_addr;
        end else if (c) begin
            mdl_err_valid = 1'b0;
            mdl_err_addr  = '0;
        end
        pend_err = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            m_req   = 1'b0;
            m_we    = 1'($urandom_range(0, 1));
            m_addr  = $urandom;
            s_ack   = 3'($urandom);
            s_rdata = rand96();
            err_clr = noise && ($urandom_range(0, 7) == 0);
            step();
        end
    endtask

    // delay = wait cycles before the selected slave acks; >= TIMEOUT never acks.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int delay, input logic [31:0] rd, input logic clr);
        int          slv;
        int          n_acc;
        logic        acked;
        logic [31:0] off;
        slv     = decode(addr);
        m_req   = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wd;
        s_ack   = 3'($urandom);
        s_rdata = rand96();
        last_t0 = cyc;
        if (slv < 0) begin
            pend_err  = 1'b1;
            pend_addr = addr;
            err_clr   = clr;
            step();
            exp_ready = 1'b1;
            exp_err   = 1'b1;
            if (!we) exp_rdata = '0;
        end else begin
            off   = addr & ~map_mask[slv];
            acked = (delay < TIMEOUT);
            n_acc = acked ? delay + 1 : TIMEOUT;
            step();
            for (int k = 1; k <= n_acc; k++) begin
                exp_sel    = 3'(3'b001 << slv);
                exp_we     = we;
                exp_saddr  = off;
                exp_swdata = wd;
                exp_ready  = 1'b0;
                s_ack      = 3'($urandom) & ~(3'(3'b001 << slv));
                s_rdata    = rand96();
                if (k == n_acc) begin
                    err_clr = clr;
                    if (acked) begin
                        s_ack[slv] = 1'b1;
                        s_rdata[slv*32 +: 32] = rd;
                    end else begin
                        pend_err  = 1'b1;
                        pend_addr = addr;
                    end
                end
                step();
            end
            exp_sel   = '0;
            exp_we    = 1'b0;
            exp_ready = 1'b1;
            exp_err   = !acked;
            if (!we) exp_rdata = acked ? rd : 32'h0;
        end
        m_req   = hold_req ? 1'b1 : 1'($urandom_range(0, 1));
        s_ack   = 3'($urandom);
        s_rdata = rand96();
        step();
        exp_ready = 1'b0;
        exp_err   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_sel", 64'(s_sel), 64'(exp_sel));
            chk("s_we", 64'(s_we), 64'(exp_we));
            chk("m_ready", 64'(m_ready), 64'(exp_ready));
            if (exp_ready) begin
                chk("m_err", 64'(m_err), 64'(exp_err));
                chk("m_rdata", 64'(m_rdata), 64'(exp_rdata));
            end
            if (exp_sel != 3'b000) begin
                chk("s_addr", 64'(s_addr), 64'(exp_saddr));
                chk("s_wdata", 64'(s_wdata), 64'(exp_swdata));
            end
            chk("err_valid", 64'(err_valid), 64'(mdl_err_valid));
            chk("err_addr", 64'(err_addr), 64'(mdl_err_addr));
            if (m_ready) begin
                obs_ready_cyc = cyc;
                obs_rdata     = m_rdata;
                obs_err       = m_err;
                n_ready++;
            end
            if (s_sel != 3'b000) begin
                if (prev_sel == 3'b000) begin
                    obs_sel_cyc = cyc;
                    obs_sel     = s_sel;
                    obs_saddr   = s_addr;
                    obs_swdata  = s_wdata;
                    obs_swe     = s_we;
                    obs_sel_len = 0;
                end
                obs_sel_len++;
            end
            prev_sel = s_sel;
        end
    end

    initial begin
        int          tmp;
        logic [31:0] a;
        map_base[0] = 32'h1001_0000; map_mask[0] = 32'hFFFF_0000;
        map_base[1] = 32'h1002_0000; map_mask[1] = 32'hFFFF_FFF0;
        map_base[2] = 32'h1003_0000; map_mask[2] = 32'hFFFF_FFF0;
        noise = 1'b0; hold_req = 1'b0; pend_err = 1'b0; pend_addr = '0;
        mdl_err_valid = 1'b0; mdl_err_addr = '0; last_t0 = 0;
        exp_sel = '0; exp_we = 1'b0; exp_saddr = '0; exp_swdata = '0;
        exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ack = '0; err_clr = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        chk("rst_m_rdata", 64'(m_rdata), 64'h0);
        chk("rst_s_addr", 64'(s_addr), 64'h0);
        chk("rst_s_wdata", 64'(s_wdata), 64'h0);
        chk("rst_err_addr", 64'(err_addr), 64'h0);
        rst = 1'b0;
        idle(2);

        chk("model_dec_uart_top", 64'(decode(32'h1002_000F)), 64'(1));
        chk("model_dec_uart_miss", 64'(decode(32'h1002_0010)), 64'(-1));

        txn(1'b0, 32'h1001_0024, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        chk("ram_sel", 64'(obs_sel), 64'h1);
        chk("ram_saddr", 64'(obs_saddr), 64'h24);
        chk("ram_latency", 64'(obs_ready_cyc - last_t0), 64'(2));
        chk("ram_rdata", 64'(obs_rdata), 64'hDEAD_BEEF);
        chk("ram_err", 64'(obs_err), 64'h0);
        idle(1);

        txn(1'b1, 32'h1002_0004, 32'h41, 3, 32'h0, 1'b0);
        chk("uart_sel", 64'(obs_sel), 64'h2);
        chk("uart_we", 64'(obs_swe), 64'h1);
        chk("uart_wdata", 64'(obs_swdata), 64'h41);
        chk("uart_sel_len", 64'(obs_sel_len), 64'(4));
        chk("uart_latency", 64'(obs_ready_cyc - last_t0), 64'(5));
        chk("uart_err", 64'(obs_err), 64'h0);
        idle(1);

        txn(1'b0, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b0);
        chk("miss_latency", 64'(obs_ready_cyc - last_t0), 64'(1));
        chk("miss_err", 64'(obs_err), 64'h1);
        chk("miss_rdata", 64'(obs_rdata), 64'h0);
        chk("miss_err_valid", 64'(err_valid), 64'h1);
        chk("miss_err_addr", 64'(err_addr), 64'h2000_0000);
        idle(1);

        txn(1'b0, 32'h1003_0008, 32'h0, 9, 32'h0, 1'b0);
        chk("gpio_sel", 64'(obs_sel), 64'h4);
        chk("gpio_sel_len", 64'(obs_sel_len), 64'(TIMEOUT));
        chk("gpio_err", 64'(obs_err), 64'h1);
        chk("gpio_latency", 64'(obs_ready_cyc - last_t0), 64'(TIMEOUT + 1));
        chk("gpio_err_addr_kept", 64'(err_addr), 64'h2000_0000);

        m_req = 1'b0; err_clr = 1'b1;
        step();
        chk("clr_err_valid", 64'(err_valid), 64'h0);
        chk("clr_err_addr", 64'(err_addr), 64'h0);
        txn(1'b0, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b0);
        txn(1'b0, 32'h3000_0000, 32'h0, 0, 32'h0, 1'b1);
        chk("clr_new_valid", 64'(err_valid), 64'h1);
        chk("clr_new_addr", 64'(err_addr), 64'h3000_0000);
        idle(1);

        tmp = n_ready;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0100; m_wdata = 32'h0; s_ack = 3'b000;
        step();
        exp_sel = 3'b001; exp_we = 1'b0; exp_saddr = 32'h100; exp_swdata = 32'h0;
        s_ack = 3'b110;
        step();
        rst = 1'b1;
        step();
        chk("abort_sel", 64'(s_sel), 64'h0);
        chk("abort_ready", 64'(m_ready), 64'h0);
        rst = 1'b0; m_req = 1'b0;
        step();
        chk("abort_no_ready", 64'(n_ready), 64'(tmp));
        txn(1'b0, 32'h1001_0008, 32'h0, 1, 32'h1234_5678, 1'b0);
        chk("post_abort_rdata", 64'(obs_rdata), 64'h1234_5678);
        chk("post_abort_err", 64'(obs_err), 64'h0);
        idle(1);

        hold_req = 1'b1;
        txn(1'b0, 32'h1001_0000, 32'h0, 0, 32'h0000_0001, 1'b0);
        tmp = obs_ready_cyc;
        txn(1'b0, 32'h1001_0004, 32'h0, 2, 32'h0000_0002, 1'b0);
        chk("b2b_sel_gap", 64'(obs_sel_cyc - tmp), 64'(2));
        chk("b2b_rdata", 64'(obs_rdata), 64'h2);
        hold_req = 1'b0;
        idle(1);

        noise = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h1001_0000 | 32'($urandom_range(0, 16'hFFFF));
                1:       a = 32'h1002_0000 | 32'($urandom_range(0, 15));
                2:       a = 32'h1003_0000 | 32'($urandom_range(0, 15));
                3:       a = 32'h1002_0000 | ($urandom & 32'h0000_FFF0);
                default: a = $urandom;
            endcase
            txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 5), $urandom,
                ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
